apb_wait_mem: RTL
=================

Name: apb_wait_mem

Overview:
Parametrised APB4 memory-mapped slave: the next-generation demonstration memory for the bus-bridge test benches. Adds a configurable wait-state count, non-power-of-two depth, a write-protected low region, and real PSLVERR generation. Sits behind any APB master or bridge (AXI-to-APB, WB-to-APB) as a checkable endpoint.

Parameters:
C_APB_ADDR_WIDTH, 12, PADDR width (AW).
C_APB_DATA_WIDTH, 32, PRDATA/PWDATA width (DW); 8, 16, 32 or 64. APBLSB = clog2(DW)-3.
MEM_WORDS, 1024, implemented words; must be >=1 and <= 2^(AW-APBLSB); need not be a power of two.
RO_WORDS, 0, words [0, RO_WORDS) are read-only; must be <= MEM_WORDS.
WAIT_STATES, 0, PREADY-low access-phase cycles before completion; 0 to 15.
PRIV_BASE, MEM_WORDS, first word index that requires privileged access (only used under the optional feature).

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset, synchronous, active-low
PSEL  in  1  slave select
PENABLE  in  1  access phase
PREADY  out  1  transfer complete, registered
PADDR  in  AW  byte address; bits [APBLSB-1:0] ignored
PWRITE  in  1  1=write
PWDATA  in  DW  write data
PWSTRB  in  DW/8  byte lanes
PPROT  in  3  protection; [0] privileged
PRDATA  out  DW  read data, registered
PSLVERR  out  1  error, valid only with PREADY

Behaviour:
- Reset (PRESETn low at a PCLK edge): state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0. No write commits on a reset cycle; reset mid-transfer abandons it.
- FSM states: IDLE, WAIT, DONE.
- IDLE: on PSEL && !PENABLE (setup), latch word index widx=PADDR[AW-1:APBLSB], PWRITE, PWDATA, PWSTRB, and err flag. Go to DONE if WAIT_STATES==0, else load counter=WAIT_STATES-1 and go to WAIT.
- err = (widx >= MEM_WORDS) || (write && widx < RO_WORDS).
- WAIT: counter decrements each cycle; go to DONE when counter==0.
- PREADY is registered: it is set on the edge that enters DONE and cleared on the next edge. Timing with setup at cycle T0: PREADY=1 exactly during cycle T1+WAIT_STATES. When WAIT_STATES=0, PREADY=1 in the first access cycle.
- DONE (PREADY=1, completion cycle): FSM returns to IDLE. A new setup is accepted from IDLE in the following cycle. The APB protocol forces one setup cycle between transfers, so back-to-back transfers cost 2+WAIT_STATES cycles each.
- Reads: PRDATA is loaded on the same edge that sets PREADY, with mem[widx] if !err, else all zeros. PRDATA holds its value otherwise.
- Writes: committed on the edge ending the completion cycle, when PSEL && PENABLE && PREADY && !err. Only lanes with a set PWSTRB bit are written; PWSTRB=0 writes nothing and is not an error.
- PSLVERR: set to err on the same edge as PREADY; 0 whenever PREADY=0.
- PSEL low while in WAIT (protocol violation): abort to IDLE, no commit, PREADY remains 0.
- Memory contents are not reset.
- Width rules: compare widx against MEM_WORDS at AW-APBLSB+1 bits to avoid truncation. The counter is 4 bits.

Optional Feature:
Macro APB_WAIT_MEM_PROT_EN.
- Defined: err additionally includes (!PPROT[0] && widx >= PRIV_BASE). An unprivileged access to [PRIV_BASE, MEM_WORDS) completes with PSLVERR=1, no write, and PRDATA=0.
- Undefined: PPROT is ignored (tied into the unused-signal sink) and PRIV_BASE has no effect.

Decomposition:
- Package apb_wait_mem_pkg holds: FSM state typedef (IDLE/WAIT/DONE), APB response constants (RESP_OK=0, RESP_ERR=1), and a function computing the err flag from widx, write, MEM_WORDS, RO_WORDS.
- One natural sub-module, apb_wait_mem_ram: byte-lane-strobed, single-port, registered-read RAM of MEM_WORDS x DW. It receives read-enable and write-enable from the FSM.
- Control, FSM and error logic stay in the top level.

Test Plan:
- WAIT_STATES=0, DW=32: write 0x12345678 to addr 0x010 with PWSTRB=0xF, then read 0x010 -> PREADY high in first access cycle; PRDATA=0x12345678; PSLVERR=0.
- WAIT_STATES=3: read 0x010 -> PREADY low for 3 access cycles, high on the 4th; PRDATA valid on that cycle.
- Write 0xAABBCCDD with PWSTRB=0x5 over 0x12345678 at 0x020, then read -> PRDATA=0x12BB56DD.
- MEM_WORDS=1000, RO_WORDS=4: read addr 0xFA0 (word 1000) -> PSLVERR=1, PRDATA=0. Write word 2 -> PSLVERR=1 and mem unchanged. Read word 2 -> PSLVERR=0.
- WAIT_STATES=5: assert PRESETn low two cycles into a write -> PREADY=0 after reset; the following read of that address returns the old value.
- APB_WAIT_MEM_PROT_EN defined, PRIV_BASE=512: write word 600 with PPROT=3'b000 -> PSLVERR=1, no write. Same write with PPROT=3'b001 -> PSLVERR=0, data stored.

Source files
------------

// File: rtl/apb_wait_mem_pkg.sv
// Shared types and helpers for the apb_wait_mem APB4 slave: FSM states,
// response codes and the address/permission error rule.
package apb_wait_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  // Word indices are widened to 32 bits so a full-range index never wraps
  // below MEM_WORDS when compared.
  function automatic logic access_err(input logic [31:0]  widx,
                                      input logic         write,
                                      input int unsigned  mem_words,
                                      input int unsigned  ro_words);
    if (widx >= mem_words)          return RESP_ERR;
    if (write && (widx < ro_words)) return RESP_ERR;
    return RESP_OK;
  endfunction

endpackage

// File: rtl/apb_wait_mem_ram.sv
// Single-port, byte-lane-strobed RAM with a registered read port.
// The read register can be cleared so an errored read returns zero.
module apb_wait_mem_ram #(
  parameter int unsigned WORDS  = 1024,
  parameter int unsigned DW     = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              rd_clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DW/8-1:0]   wstrb,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [WORDS];

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // read register below is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(DW / 8); b++) begin
        if (wstrb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || rd_clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/apb_wait_mem.sv
// APB4 memory slave with programmable wait states, read-only low region and
// PSLVERR. Optional privileged region enabled by APB_WAIT_MEM_PROT_EN.
module apb_wait_mem
  import apb_wait_mem_pkg::*;
#(
  parameter int unsigned C_APB_ADDR_WIDTH = 12,
  parameter int unsigned C_APB_DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS        = 1024,
  parameter int unsigned RO_WORDS         = 0,
  parameter int unsigned WAIT_STATES      = 0,
  parameter int unsigned PRIV_BASE        = MEM_WORDS
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  output logic                          PREADY,
  input  logic [C_APB_ADDR_WIDTH-1:0]   PADDR,
  input  logic                          PWRITE,
  input  logic [C_APB_DATA_WIDTH-1:0]   PWDATA,
  input  logic [C_APB_DATA_WIDTH/8-1:0] PWSTRB,
  input  logic [2:0]                    PPROT,
  output logic [C_APB_DATA_WIDTH-1:0]   PRDATA,
  output logic                          PSLVERR
);

  localparam int unsigned AW     = C_APB_ADDR_WIDTH;
  localparam int unsigned DW     = C_APB_DATA_WIDTH;
  localparam int unsigned NB     = DW / 8;
  localparam int unsigned APBLSB = $clog2(DW) - 3;
  localparam int unsigned IDX_W  = AW - APBLSB;
  localparam int unsigned RAM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_q;
  logic             write_q;
  logic             err_q;
  logic [DW-1:0]    wdata_q;
  logic [NB-1:0]    wstrb_q;

  logic [IDX_W-1:0] setup_idx;
  logic             setup_err;
  logic             setup_req;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_write;
  logic             cur_err;
  logic             go_done;
  logic             rd_en;
  logic             rd_clr;
  logic             wr_en;

  assign setup_idx = PADDR[AW-1:APBLSB];
  assign setup_req = PSEL && !PENABLE;

  always_comb begin
    setup_err = access_err(32'(setup_idx), PWRITE, MEM_WORDS, RO_WORDS);
`ifdef APB_WAIT_MEM_PROT_EN
    if (!PPROT[0] && (32'(setup_idx) >= PRIV_BASE)) setup_err = RESP_ERR;
`endif
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (setup_req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!PSEL)            state_nxt = IDLE;
        else if (cnt == 4'd0) state_nxt = DONE;
        else                  cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // DONE can be entered straight from IDLE, before the request is latched,
  // so the RAM and error flag look at the live bus in that state.
  always_comb begin
    cur_idx   = idx_q;
    cur_write = write_q;
    cur_err   = err_q;
    if (state == IDLE) begin
      cur_idx   = setup_idx;
      cur_write = PWRITE;
      cur_err   = setup_err;
    end
  end

  assign go_done = (state_nxt == DONE);
  assign rd_en   = go_done && !cur_write && !cur_err;
  assign rd_clr  = go_done && !cur_write && cur_err;
  assign wr_en   = PRESETn && (state == DONE) && PSEL && PENABLE && PREADY
                   && write_q && !err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= RESP_OK;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= RESP_OK;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      PREADY  <= go_done;
      PSLVERR <= go_done ? cur_err : RESP_OK;
      if ((state == IDLE) && setup_req) begin
        idx_q   <= setup_idx;
        write_q <= PWRITE;
        err_q   <= setup_err;
        wdata_q <= PWDATA;
        wstrb_q <= PWSTRB;
      end
    end
  end

  apb_wait_mem_ram #(
    .WORDS  (MEM_WORDS),
    .DW     (DW),
    .ADDR_W (RAM_AW)
  ) u_ram (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .re     (rd_en),
    .rd_clr (rd_clr),
    .we     (wr_en),
    .addr   (cur_idx[RAM_AW-1:0]),
    .wstrb  (wstrb_q),
    .wdata  (wdata_q),
    .rdata  (PRDATA)
  );

  logic unused_sink;
`ifdef APB_WAIT_MEM_PROT_EN
  assign unused_sink = &{1'b0, PPROT[2:1], PADDR, cur_idx};
`else
  assign unused_sink = &{1'b0, PPROT, PADDR, cur_idx};
`endif

endmodule
